// File: rtl/r_type_encoder.sv
// RV32I R-type instruction encoder feeding a DEPTH-entry output FIFO.
// Requests with a non-one-hot op are consumed, flagged and counted, and never queued.
module r_type_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [9:0]               op,
  input  logic [4:0]               rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     illegal,
  output logic [7:0]               illegal_count,
  output logic [15:0]              emitted_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);
  localparam logic [6:0] OpcodeOp = 7'b0110011;
  localparam logic [6:0] Funct7Alt = 7'b0100000;

  // Decode
  logic       legal;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [31:0] word;

  always_comb begin
    legal  = 1'b1;
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    unique case (op)
      10'b00_0000_0001: funct3 = 3'b000;                      // add
      10'b00_0000_0010: begin funct3 = 3'b000; funct7 = Funct7Alt; end // sub
      10'b00_0000_0100: funct3 = 3'b001;                      // sll
      10'b00_0000_1000: funct3 = 3'b010;                      // slt
      10'b00_0001_0000: funct3 = 3'b011;                      // sltu
      10'b00_0010_0000: funct3 = 3'b100;                      // xor
      10'b00_0100_0000: funct3 = 3'b101;                      // srl
      10'b00_1000_0000: begin funct3 = 3'b101; funct7 = Funct7Alt; end // sra
      10'b01_0000_0000: funct3 = 3'b110;                      // or
      10'b10_0000_0000: funct3 = 3'b111;                      // and
      default:          legal  = 1'b0;
    endcase
  end

  assign word = {funct7, rs2, rs1, funct3, rd, OpcodeOp};

  // State
  logic              ready_q;
  logic [LW-1:0]     level_q, level_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic              illegal_q, illegal_d;
  logic [7:0]        illegal_count_q, illegal_count_d;
  logic [15:0]       emitted_count_q, emitted_count_d;
  logic [31:0]       mem [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // ready_q keeps in_ready low during reset and until the first edge after it
  assign in_ready  = ready_q && (level_q != FullLevel);
  assign out_valid = (level_q != '0);
  assign out_data  = mem[rd_ptr_q];
  assign level     = level_q;
  assign illegal   = illegal_q;
  assign illegal_count = illegal_count_q;
  assign emitted_count = emitted_count_q;

  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready;

  always_comb begin
    level_d         = level_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    illegal_d       = accept && !legal;
    illegal_count_d = illegal_count_q;
    emitted_count_d = emitted_count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d        = rd_ptr_q + PW'(1);
      emitted_count_d = emitted_count_q + 16'd1;
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (accept && !legal && (illegal_count_q != 8'hFF)) begin
      illegal_count_d = illegal_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q         <= 1'b0;
      level_q         <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      illegal_q       <= 1'b0;
      illegal_count_q <= '0;
      emitted_count_q <= '0;
    end else begin
      ready_q         <= 1'b1;
      level_q         <= level_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      illegal_q       <= illegal_d;
      illegal_count_q <= illegal_count_d;
      emitted_count_q <= emitted_count_d;
    end
  end

  // Storage needs no reset; out_data is don't-care while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= word;
    end
  end

endmodule

// File: tb/tb_r_type_encoder.sv
// Directed, table-driven bench for r_type_encoder (DEPTH = 4) with hand-computed words.
module tb_r_type_encoder;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  level;
  logic        illegal;
  logic [7:0]  illegal_count;
  logic [15:0] emitted_count;

  r_type_encoder #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op            (op),
    .rd            (rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .level         (level),
    .illegal       (illegal),
    .illegal_count (illegal_count),
    .emitted_count (emitted_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [9:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        bad;
    logic [31:0] word;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_emit = 0;
  int exp_ill  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{op: 10'h001, rd: 5'd1,  rs1: 5'd2,  rs2: 5'd3,  bad: 1'b0, word: 32'h003100B3};
    vecs[1]  = '{op: 10'h002, rd: 5'd5,  rs1: 5'd6,  rs2: 5'd7,  bad: 1'b0, word: 32'h407302B3};
    vecs[2]  = '{op: 10'h080, rd: 5'd31, rs1: 5'd31, rs2: 5'd31, bad: 1'b0, word: 32'h41FFDFB3};
    vecs[3]  = '{op: 10'h020, rd: 5'd10, rs1: 5'd11, rs2: 5'd12, bad: 1'b0, word: 32'h00C5C533};
    vecs[4]  = '{op: 10'h200, rd: 5'd0,  rs1: 5'd1,  rs2: 5'd2,  bad: 1'b0, word: 32'h0020F033};
    vecs[5]  = '{op: 10'h004, rd: 5'd3,  rs1: 5'd4,  rs2: 5'd5,  bad: 1'b0, word: 32'h005211B3};
    vecs[6]  = '{op: 10'h008, rd: 5'd1,  rs1: 5'd1,  rs2: 5'd1,  bad: 1'b0, word: 32'h0010A0B3};
    vecs[7]  = '{op: 10'h010, rd: 5'd2,  rs1: 5'd3,  rs2: 5'd4,  bad: 1'b0, word: 32'h0041B133};
    vecs[8]  = '{op: 10'h040, rd: 5'd7,  rs1: 5'd8,  rs2: 5'd9,  bad: 1'b0, word: 32'h009453B3};
    vecs[9]  = '{op: 10'h100, rd: 5'd31, rs1: 5'd0,  rs2: 5'd31, bad: 1'b0, word: 32'h01F06FB3};
    vecs[10] = '{op: 10'h000, rd: 5'd1,  rs1: 5'd2,  rs2: 5'd3,  bad: 1'b1, word: 32'h0};
    vecs[11] = '{op: 10'h300, rd: 5'd1,  rs1: 5'd2,  rs2: 5'd3,  bad: 1'b1, word: 32'h0};
    vecs[12] = '{op: 10'h3FF, rd: 5'd0,  rs1: 5'd0,  rs2: 5'd0,  bad: 1'b1, word: 32'h0};
    vecs[13] = '{op: 10'h001, rd: 5'd0,  rs1: 5'd0,  rs2: 5'd0,  bad: 1'b0, word: 32'h00000033};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0;

    // Reset state, sampled before any clock edge
    #3;
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_ill_cnt", 32'(illegal_count), 32'd0);
    check("rst_emit_cnt", 32'(emitted_count), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("ready_low_before_edge", 32'(in_ready), 32'd0);
    tick();
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Table: one request at a time, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      op = vecs[i].op; rd = vecs[i].rd; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].bad));
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(!vecs[i].bad));
      if (!vecs[i].bad) check($sformatf("v%0d_word", i), out_data, vecs[i].word);
      if (vecs[i].bad) exp_ill++;
      else exp_emit++;
      tick();
      check($sformatf("v%0d_illegal_drop", i), 32'(illegal), 32'd0);
      check($sformatf("v%0d_level", i), 32'(level), 32'd0);
      check($sformatf("v%0d_emit_cnt", i), 32'(emitted_count), 32'(exp_emit));
      check($sformatf("v%0d_ill_cnt", i), 32'(illegal_count), 32'(exp_ill));
    end

    // Fill to full with consumer stalled; fifth request must wait
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; op = 10'h001; rd = 5'(k); rs1 = '0; rs2 = '0;
      tick();
    end
    check("full_level", 32'(level), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head", out_data, 32'h000000B3);
    tick();
    check("stall_level", 32'(level), 32'd4);
    check("stall_head", out_data, 32'h000000B3);
    check("stall_valid", 32'(out_valid), 32'd1);

    // Drain; the pop at full frees space only on the following cycle
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d_word", k), out_data, (32'(k) << 7) | 32'h33);
      tick();
      exp_emit++;
      if (k == 1) begin
        check("after_full_pop_level", 32'(level), 32'd3);
        check("after_full_pop_ready", 32'(in_ready), 32'd1);
      end
      if (k == 2) begin
        check("push_pop_level", 32'(level), 32'd3);
        in_valid = 1'b0;
      end
    end
    check("drained_level", 32'(level), 32'd0);
    check("drained_valid", 32'(out_valid), 32'd0);
    check("drained_emit_cnt", 32'(emitted_count), 32'(exp_emit));

    // Two back-to-back illegal requests
    in_valid = 1'b1; op = 10'b0000000011;
    tick();
    check("ill_a_pulse", 32'(illegal), 32'd1);
    op = 10'b0;
    tick();
    check("ill_b_pulse", 32'(illegal), 32'd1);
    in_valid = 1'b0;
    tick();
    exp_ill += 2;
    check("ill_pair_end", 32'(illegal), 32'd0);
    check("ill_pair_cnt", 32'(illegal_count), 32'(exp_ill));
    check("ill_pair_level", 32'(level), 32'd0);
    check("ill_pair_valid", 32'(out_valid), 32'd0);

    // Saturation
    in_valid = 1'b1; op = 10'b0;
    for (int k = 0; k < 256; k++) tick();
    in_valid = 1'b0;
    tick();
    check("ill_saturated", 32'(illegal_count), 32'd255);

    // Asynchronous reset with three words queued and an illegal pulse pending
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      op = 10'h200; rd = 5'(k); rs1 = 5'(k); rs2 = 5'(k);
      tick();
    end
    op = 10'h000;
    tick();
    in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 32'd3);
    check("pre_rst_illegal", 32'(illegal), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_level", 32'(level), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_illegal", 32'(illegal), 32'd0);
    check("async_rst_ill_cnt", 32'(illegal_count), 32'd0);
    check("async_rst_emit_cnt", 32'(emitted_count), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Fresh transaction after reset
    out_ready = 1'b1; in_valid = 1'b1;
    op = 10'h001; rd = 5'd1; rs1 = 5'd2; rs2 = 5'd3;
    tick();
    in_valid = 1'b0;
    check("post_rst_word", out_data, 32'h003100B3);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    tick();
    check("post_rst_emit_cnt", 32'(emitted_count), 32'd1);
    check("post_rst_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/r_type_encoder.md
R_TYPE_ENCODER -- requirements
Module: r_type_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request carries an instruction to encode.
REQ-005 SHALL have port in_ready  output  1  encoder can accept a request this cycle.
REQ-006 SHALL have port op  input  10  one-hot kind: bit0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
REQ-007 SHALL have port rd  input  5  destination register index.
REQ-008 SHALL have port rs1  input  5  source register 1 index.
REQ-009 SHALL have port rs2  input  5  source register 2 index.
REQ-010 SHALL have port out_valid  output  1  out_data holds an encoded word.
REQ-011 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-012 SHALL have port out_data  output  32  encoded RV32I R-type instruction word.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port illegal  output  1  one-cycle pulse: accepted request had invalid op.
REQ-015 SHALL have port illegal_count  output  8  saturating count of illegal requests.
REQ-016 SHALL have port emitted_count  output  16  wrapping count of words popped.

Function
REQ-017 SHALL accept a request on a rising edge where in_valid && in_ready; in_ready = (level != DEPTH).
REQ-018 SHALL encode word = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
REQ-019 SHALL use funct3: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111.
REQ-020 SHALL use funct7 7'b0100000 for sub and sra, 7'b0000000 for all other kinds.
REQ-021 SHALL treat op with zero or more than one bit set as illegal: request consumed, nothing written to FIFO, illegal high exactly the cycle after acceptance, illegal_count += 1 saturating at 255.
REQ-022 SHALL write legal words into a DEPTH-entry circular FIFO; read/write pointers wrap modulo DEPTH.
REQ-023 SHALL present a word written into an empty FIFO on out_data with out_valid=1 in the cycle after acceptance (1-cycle latency, no combinational in->out path).
REQ-024 SHALL pop the head on a rising edge where out_valid && out_ready and increment emitted_count, wrapping 65535->0.
REQ-025 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL, on simultaneous push and pop with 0<level<DEPTH, keep level unchanged and preserve order.
REQ-027 SHALL, when full, deassert in_ready; a pop in that cycle frees space visible as in_ready=1 the next cycle only.
REQ-028 SHALL drive out_valid = (level != 0); out_data is don't-care when out_valid=0.
REQ-029 SHALL preserve strict FIFO order of legal words; illegal requests create no gaps.
REQ-030 SHALL not depend on rd/rs1/rs2 values for legality; x0 as rd encodes normally.

Reset
REQ-031 SHALL, while rst is high, force level=0, pointers=0, out_valid=0, illegal=0, illegal_count=0, emitted_count=0, in_ready=0.
REQ-032 SHALL drive in_ready=1 from the first rising edge after rst deasserts.
REQ-033 SHALL discard all buffered words and any pending illegal pulse when rst asserts mid-operation.

Verification
REQ-034 SHALL verify add rd=1 rs1=2 rs2=3, out_ready=1 -> out_data=0x003100B3 next cycle, emitted_count=1.
REQ-035 SHALL verify sub rd=5 rs1=6 rs2=7 -> 0x407302B3; sra rd=31 rs1=31 rs2=31 -> 0x41FFDFB3.
REQ-036 SHALL verify out_ready=0, 5 back-to-back legal requests with DEPTH=4 -> 4 accepted, level=4, in_ready=0, 5th held; then drain -> words in order, emitted_count=4.
REQ-037 SHALL verify op=10'b0000000011 then op=0 -> two illegal pulses, illegal_count=2, level=0, out_valid=0.
REQ-038 SHALL verify 256 illegal requests -> illegal_count=255 (saturated).
REQ-039 SHALL verify rst asserted with level=3 -> out_valid=0, level=0, counters 0 immediately, without waiting for clk.
